axis_frame_fifo: RTL
====================

// Module: axis_frame_fifo
// PURPOSE
// Store-and-forward AXI-Stream FIFO placed directly downstream of the framer.
// Buffers words until the framer's tlast completes a frame, then releases the whole frame contiguously.
// Guarantees the consumer (DMA/packetiser) never sees a partial frame or mid-frame stall from the source.
// Frames larger than the buffer are dropped whole and counted.
// PARAMETERS
// DATA_WIDTH   32   width of tdata
// DEPTH        256  buffer depth in words; power of two, >= 2
// ADDR_W       $clog2(DEPTH)  derived, do not override
// PORTS
// clk             in   1             single clock; all logic on posedge
// reset           in   1             synchronous, active-high
// s_axis_tdata    in   DATA_WIDTH    input word from framer
// s_axis_tvalid   in   1             input valid
// s_axis_tready   out  1             input ready
// s_axis_tlast    in   1             last word of frame
// m_axis_tdata    out  DATA_WIDTH    output word
// m_axis_tvalid   out  1             output valid (registered)
// m_axis_tready   in   1             output ready
// m_axis_tlast    out  1             last word of frame (registered)
// frame_count     out  ADDR_W+1      complete frames held, incl. one in output reg
// drop_count      out  16            oversize frames dropped, saturating
// BEHAVIOUR
// - Reset (sync, high): wr_ptr = commit_ptr = rd_ptr = 0, state IDLE, m_axis_tvalid = 0, m_axis_tlast = 0,
//   m_axis_tdata = 0, frame_count = 0, drop_count = 0. Buffered data is discarded, even mid-frame.
// - Memory: DEPTH x (DATA_WIDTH+1), stores {tlast,tdata}.
// - Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH. full = (wr_ptr - rd_ptr) == DEPTH.
// - Write FSM, states IDLE (between frames), WRITE (mid-frame), DROP (discarding oversize frame):
//   * s_axis_tready = (state==DROP) | !full.
//   * On a handshake outside DROP: mem[wr_ptr] <= word; wr_ptr++; state <= WRITE.
//     If tlast: commit_ptr <= wr_ptr+1; state <= IDLE.
//   * Oversize: full & (commit_ptr==rd_ptr) & s_axis_tvalid -> state <= DROP, wr_ptr <= commit_ptr,
//     drop_count++ (saturating at 16'hFFFF).
//   * DROP: accept and discard every word; on tlast handshake go to IDLE. No commit, no frame_count change.
//   * A tlast word that arrives while in DROP ends the drop; the next word starts a fresh frame.
// - Read side: only words below commit_ptr are visible.
//   * The output reg loads mem[rd_ptr] and rd_ptr++ when (rd_ptr != commit_ptr) & (!m_axis_tvalid | m_axis_tready).
//     m_axis_tvalid deasserts when the output handshakes and no committed word remains.
//   * Latency: tlast accepted at edge E0 (commit at E0); the first word is valid after E1.
//     Then 1 word/cycle while m_axis_tready = 1.
//   * Output holds tdata/tlast stable while tvalid & !tready (AXI-S rule).
// - frame_count: +1 on commit, -1 on m_axis tlast handshake, unchanged when both occur in the same cycle.
// - Simultaneous write and read in the same cycle are legal. full uses the rd_ptr value at the edge; no bypass.
// - Pointer wrap is transparent: frames may straddle address DEPTH-1 -> 0.
// TESTING
// DEPTH=16, DATA_WIDTH=32 unless stated.
// 1) One 4-word frame 0xA0..0xA3, m_ready=1 -> no m_valid before tlast accepted; 4 words 1 cycle after, tlast on 0xA3.
// 2) Three back-to-back 5-word frames, m_ready=0 until all in -> frame_count=3, s_ready stays 1 (15<16); drain is in order.
// 3) 20-word frame into empty FIFO -> drop_count=1, no output words; following 3-word frame is delivered intact.
// 4) 10-word frame stored, then a 10-word frame with m_ready=0 -> s_ready=0 at 16 words.
//    Releasing m_ready drains frame 1 and then frame 2 in full.
// 5) Random m_ready (50%), 200 frames of length 1..12 across pointer wrap -> scoreboard match, tdata stable during stalls.
// 6) reset=1 for 1 cycle mid-frame with 2 frames queued -> next cycle m_valid=0, frame_count=0, s_ready=1.

Source files
------------

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: store-and-forward AXI-Stream FIFO that releases only complete frames.
// Frames too large for the buffer are discarded whole and counted in drop_count.
module axis_frame_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ADDR_W:0]       frame_count,
    output logic [15:0]           drop_count
);
    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] used;
    logic             full;
    logic             s_hs;
    logic             store;
    logic             commit;
    logic             oversize;
    logic             load;
    logic             m_hs;
    logic             m_last_hs;

    // Occupancy counts every word written but not yet moved into the output register.
    assign used          = wr_ptr - rd_ptr;
    assign full          = (used == PTR_W'(DEPTH));
    assign s_axis_tready = (state == DROP) || !full;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign store         = s_hs && (state != DROP);
    assign commit        = store && s_axis_tlast;

    // The in-progress frame fills the whole buffer and nothing can drain: it can never fit.
    assign oversize = (state != DROP) && full && (commit_ptr == rd_ptr) && s_axis_tvalid;

    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign m_last_hs = m_hs && m_axis_tlast;
    assign load      = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WRITE: begin
                if (oversize) begin
                    state_nxt = DROP;
                end else if (commit) begin
                    state_nxt = IDLE;
                end else if (store) begin
                    state_nxt = WRITE;
                end
            end
            DROP: begin
                if (s_hs && s_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame storage; only committed entries are ever read, so no write/read bypass is needed
    always_ff @(posedge clk) begin
        if (store && !reset) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Write and commit pointers; an oversize frame rewinds to the last commit point
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else if (oversize) begin
            wr_ptr <= commit_ptr;
        end else if (store) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (s_axis_tlast) begin
                commit_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Saturating count of dropped frames
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (oversize && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Output register: loads the next committed word whenever it is empty or being consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (load) begin
            rd_ptr        <= rd_ptr + PTR_W'(1);
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= mem[rd_ptr[ADDR_W-1:0]].last;
            m_axis_tdata  <= mem[rd_ptr[ADDR_W-1:0]].data;
        end else if (m_hs) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Complete frames held, including one sitting in the output register
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else begin
            case ({commit, m_last_hs})
                2'b10:   frame_count <= frame_count + PTR_W'(1);
                2'b01:   frame_count <= frame_count - PTR_W'(1);
                default: frame_count <= frame_count;
            endcase
        end
    end

endmodule
